// File: rtl/amstrad_mem_pkg.sv
// amstrad_mem_pkg: shared tag type and slot constants for the SDRAM slot arbiter
package amstrad_mem_pkg;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} mem_tag_e;
    localparam logic [3:0] PH_VID = 4'd0;
    localparam logic [3:0] PH_CPU = 4'd8;
    localparam int FRAME_LEN = 16;
endpackage

// File: rtl/mem_req_latch.sv
// mem_req_latch: request capture with pending flag, edge-detect or strobe mode
module mem_req_latch #(
    parameter int ADDR_W = 23,
    parameter bit EDGE = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req,
    input  logic              we_in,
    input  logic              en,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        bank,
    input  logic [7:0]        din,
    output logic              pend,
    output logic              we,
    output logic [ADDR_W-1:0] addr_q,
    output logic [1:0]        bank_q,
    output logic [7:0]        din_q
);
    logic req_d;
    logic take;

    // edge mode ignores new edges while pending; strobe mode lets a new strobe overwrite
    assign take = en && req && (EDGE ? (!req_d && !pend) : 1'b1);

    // capture request fields; a fresh capture wins over a same-cycle clear
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            req_d  <= 1'b0;
            pend   <= 1'b0;
            we     <= 1'b0;
            addr_q <= '0;
            bank_q <= '0;
            din_q  <= '0;
        end else begin
            req_d <= req;
            if (take) begin
                pend   <= 1'b1;
                we     <= we_in;
                addr_q <= addr;
                bank_q <= bank;
                din_q  <= din;
            end else if (clr) begin
                pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: 16-cycle time-slot sharing of the SDRAM core between video, CPU and boot loader
module sdram_slot_arbiter
    import amstrad_mem_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int RD_LAT = 5,
    parameter logic [6:0] VID_HI = 7'b1000000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clkref,
    input  logic              boot_mode,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [1:0]        boot_bank,
    input  logic [7:0]        boot_din,
    output logic              boot_ack,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_bank,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic [15:0]       vid_addr,
    input  logic [1:0]        vid_bank,
    output logic [7:0]        vid_dout,
    output logic              vid_valid,
    output logic              sd_cmd_valid,
    output logic              sd_cmd_we,
    output logic [ADDR_W-1:0] sd_cmd_addr,
    output logic [1:0]        sd_cmd_bank,
    output logic [7:0]        sd_cmd_din,
    input  logic              sd_rd_valid,
    input  logic [7:0]        sd_rd_data
);
    generate
        if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
            $error("sdram_slot_arbiter: RD_LAT must be 1..7");
        end
    endgenerate

    logic [3:0]        phase, phase_n, cnt;
    mem_tag_e          tag;
    logic              boot_pend, boot_we, cpu_pend, cpu_we;
    logic [ADDR_W-1:0] boot_a, cpu_a, cmd_addr_n;
    logic [1:0]        boot_b, cpu_b, cmd_bank_n;
    logic [7:0]        boot_d, cpu_d, cmd_din_n;
    logic              tmo, tag_free, vid_go, boot_go, cpu_go, rd_go, cmd_we_n;

    mem_req_latch #(.ADDR_W(ADDR_W), .EDGE(1'b0)) u_boot (
        .clk_sys(clk_sys), .reset(reset), .req(boot_req), .we_in(1'b1), .en(1'b1), .clr(boot_go),
        .addr(boot_addr), .bank(boot_bank), .din(boot_din),
        .pend(boot_pend), .we(boot_we), .addr_q(boot_a), .bank_q(boot_b), .din_q(boot_d)
    );

    mem_req_latch #(.ADDR_W(ADDR_W), .EDGE(1'b1)) u_cpu (
        .clk_sys(clk_sys), .reset(reset), .req(cpu_rd | cpu_wr), .we_in(cpu_wr), .en(!boot_mode), .clr(cpu_go),
        .addr(cpu_addr), .bank(cpu_bank), .din(cpu_din),
        .pend(cpu_pend), .we(cpu_we), .addr_q(cpu_a), .bank_q(cpu_b), .din_q(cpu_d)
    );

    // slot decisions are made against the phase of the next cycle so command outputs can be registered
    always_comb begin
        phase_n    = clkref ? 4'd0 : (phase == 4'(FRAME_LEN - 1) ? phase : phase + 4'd1);
        tmo        = tag != TAG_NONE && cnt == 4'(RD_LAT + 2);
        tag_free   = tag == TAG_NONE || sd_rd_valid || tmo;
        vid_go     = !sd_cmd_valid && phase_n == PH_VID && !boot_mode && tag_free;
        boot_go    = !sd_cmd_valid && phase_n == PH_CPU && boot_pend;
        cpu_go     = !sd_cmd_valid && phase_n == PH_CPU && !boot_pend && cpu_pend && !boot_mode && (cpu_we || tag_free);
        rd_go      = vid_go || (cpu_go && !cpu_we);
        cmd_we_n   = boot_go ? boot_we : (cpu_go && cpu_we);
        cmd_addr_n = vid_go ? ADDR_W'({VID_HI, vid_addr}) : boot_go ? boot_a : cpu_go ? cpu_a : '0;
        cmd_bank_n = vid_go ? vid_bank : boot_go ? boot_b : cpu_go ? cpu_b : 2'd0;
        cmd_din_n  = boot_go ? boot_d : (cpu_go && cpu_we) ? cpu_d : 8'd0;
    end

    // phase, read tag with timeout, command strobe and read-data steering
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            phase        <= 4'd15;
            tag          <= TAG_NONE;
            cnt          <= 4'd0;
            sd_cmd_valid <= 1'b0;
            sd_cmd_we    <= 1'b0;
            sd_cmd_addr  <= '0;
            sd_cmd_bank  <= 2'd0;
            sd_cmd_din   <= 8'd0;
            boot_ack     <= 1'b0;
            cpu_ack      <= 1'b0;
            vid_valid    <= 1'b0;
            cpu_dout     <= 8'hFF;
            vid_dout     <= 8'hFF;
        end else begin
            phase        <= phase_n;
            tag          <= vid_go ? TAG_VID : (cpu_go && !cpu_we) ? TAG_CPU : tag_free ? TAG_NONE : tag;
            cnt          <= (rd_go || tag == TAG_NONE) ? 4'd0 : cnt + 4'd1;
            sd_cmd_valid <= vid_go || boot_go || cpu_go;
            sd_cmd_we    <= cmd_we_n;
            sd_cmd_addr  <= cmd_addr_n;
            sd_cmd_bank  <= cmd_bank_n;
            sd_cmd_din   <= cmd_din_n;
            boot_ack     <= boot_go;
            cpu_ack      <= (cpu_go && cpu_we) || (sd_rd_valid && tag == TAG_CPU);
            vid_valid    <= sd_rd_valid && tag == TAG_VID;
            cpu_dout     <= (sd_rd_valid && tag == TAG_CPU) ? sd_rd_data : cpu_dout;
            vid_dout     <= (sd_rd_valid && tag == TAG_VID) ? sd_rd_data : vid_dout;
        end
    end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: directed scoreboard bench for the SDRAM slot arbiter
module tb_sdram_slot_arbiter;
    import amstrad_mem_pkg::*;
    localparam int RD_LAT = 5;

    logic        clk_sys = 1'b0, reset = 1'b1, clkref = 1'b0, boot_mode = 1'b1, boot_req = 1'b0;
    logic [22:0] boot_addr = '0, cpu_addr = '0, sd_cmd_addr;
    logic [1:0]  boot_bank = '0, cpu_bank = '0, vid_bank = '0, sd_cmd_bank;
    logic [7:0]  boot_din = '0, cpu_din = '0, cpu_dout, vid_dout, sd_cmd_din, sd_rd_data = '0;
    logic        boot_ack, cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_ack, vid_valid;
    logic [15:0] vid_addr = '0;
    logic        sd_cmd_valid, sd_cmd_we, sd_rd_valid = 1'b0;

    typedef struct packed {logic we; logic [22:0] addr; logic [1:0] bank; logic [7:0] din; logic [3:0] ph;} cmd_t;
    typedef struct packed {logic [2:0] kind; logic [7:0] data; logic [3:0] ph;} ack_t;
    cmd_t cmdq[$];
    ack_t ackq[$];
    cmd_t ce, co;
    ack_t ae, ao;
    int   checks = 0, errors = 0, cd = 0;
    logic [3:0] ph = 4'd15;
    logic clk_en = 1'b0, core_mute = 1'b0, cd_vid = 1'b0, prev_cmd = 1'b0;
    logic [7:0] vid_data = '0, cpu_data = '0;

    sdram_slot_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .clkref(clkref), .boot_mode(boot_mode),
        .boot_req(boot_req), .boot_addr(boot_addr), .boot_bank(boot_bank), .boot_din(boot_din), .boot_ack(boot_ack),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .vid_addr(vid_addr), .vid_bank(vid_bank),
        .vid_dout(vid_dout), .vid_valid(vid_valid), .sd_cmd_valid(sd_cmd_valid), .sd_cmd_we(sd_cmd_we),
        .sd_cmd_addr(sd_cmd_addr), .sd_cmd_bank(sd_cmd_bank), .sd_cmd_din(sd_cmd_din),
        .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data)
    );

    always #5 clk_sys = ~clk_sys;

    // reference frame phase
    always @(posedge clk_sys) ph <= reset ? 4'd15 : clkref ? 4'd0 : (ph == 4'd15 ? ph : ph + 4'd1);

    // clkref generator and SDRAM core model returning data RD_LAT cycles after a read command
    always @(negedge clk_sys) begin
        sd_rd_valid = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0 && !core_mute) begin
                sd_rd_valid = 1'b1;
                sd_rd_data = cd_vid ? vid_data : cpu_data;
            end
        end
        if (sd_cmd_valid && !sd_cmd_we) begin
            cd = RD_LAT;
            cd_vid = sd_cmd_addr[22:16] == 7'h40;
        end
        clkref = clk_en && ph == 4'd15;
    end

    // scoreboard: compare every command and every ack pulse against the expectation queues
    always @(negedge clk_sys) begin
        if (sd_cmd_valid) begin
            checks++;
            assert (!prev_cmd) else begin errors++; $error("FAIL cmd_gap back-to-back command at ph %0d", ph); end
            checks++;
            assert (cmdq.size() != 0) else begin errors++; $error("FAIL cmd_unexpected addr=%h we=%b ph=%0d", sd_cmd_addr, sd_cmd_we, ph); end
            if (cmdq.size() != 0) begin
                ce = cmdq.pop_front();
                co = '{sd_cmd_we, sd_cmd_addr, sd_cmd_bank, sd_cmd_we ? sd_cmd_din : 8'h0, ph};
                checks++;
                assert (co === ce) else begin errors++; $error("FAIL cmd obs=%h exp=%h", co, ce); end
            end
        end
        prev_cmd = sd_cmd_valid;
        if (cpu_ack || vid_valid || boot_ack) begin
            checks++;
            assert (ackq.size() != 0) else begin errors++; $error("FAIL ack_unexpected cpu=%b vid=%b boot=%b ph=%0d", cpu_ack, vid_valid, boot_ack, ph); end
            if (ackq.size() != 0) begin
                ae = ackq.pop_front();
                ao = '{{cpu_ack, vid_valid, boot_ack}, cpu_ack ? cpu_dout : vid_valid ? vid_dout : 8'h0, ph};
                checks++;
                assert (ao === ae) else begin errors++; $error("FAIL ack obs=%h exp=%h", ao, ae); end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic at(input logic [3:0] p);
        int n = 0;
        tick();
        while (ph != p && n < 64) begin
            tick();
            n++;
        end
        checks++;
        assert (ph == p) else begin errors++; $error("FAIL wait_ph obs=%0d exp=%0d", ph, p); end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin errors++; $error("FAIL %s obs=%h exp=%h", name, obs, exp); end
    endtask

    task automatic exp_vid(input logic [15:0] a, input logic [1:0] b, input logic [7:0] d);
        vid_addr = a;
        vid_bank = b;
        vid_data = d;
        cmdq.push_back(cmd_t'{1'b0, {7'h40, a}, b, 8'h0, 4'd0});
        ackq.push_back(ack_t'{3'b010, d, 4'(RD_LAT + 1)});
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_cmd_valid", 32'(sd_cmd_valid), 32'd0);
        chk("rst_cmd_addr", 32'(sd_cmd_addr), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
        chk("rst_vid_dout", 32'(vid_dout), 32'hFF);
        chk("rst_strobes", 32'({cpu_ack, vid_valid, boot_ack}), 32'd0);
        chk("rst_tag", 32'(dut.tag), 32'(TAG_NONE));
        chk("rst_phase", 32'(dut.phase), 32'd15);
        // video read, then CPU write held high
        boot_mode = 1'b0;
        exp_vid(16'h1234, 2'd1, 8'hA5);
        clk_en = 1'b1;
        at(3);
        cpu_wr = 1'b1; cpu_addr = 23'h00C000; cpu_bank = 2'd2; cpu_din = 8'h3C;
        cmdq.push_back(cmd_t'{1'b1, 23'h00C000, 2'd2, 8'h3C, 4'd8});
        ackq.push_back(ack_t'{3'b100, 8'hFF, 4'd8});
        at(7);
        chk("vid_dout_a5", 32'(vid_dout), 32'hA5);
        at(12);
        exp_vid(16'hBEEF, 2'd0, 8'h77);
        at(10);
        chk("hold_wr_cmdq", 32'(cmdq.size()), 32'd0);
        chk("hold_wr_ackq", 32'(ackq.size()), 32'd0);
        cpu_wr = 1'b0;
        at(12);
        exp_vid(16'h0000, 2'd3, 8'h11);
        // CPU read after its slot; falls before service
        at(9);
        exp_vid(16'h4242, 2'd2, 8'hC6);
        cpu_rd = 1'b1; cpu_addr = 23'h012345; cpu_bank = 2'd3; cpu_data = 8'h5A;
        cmdq.push_back(cmd_t'{1'b0, 23'h012345, 2'd3, 8'h0, 4'd8});
        ackq.push_back(ack_t'{3'b100, 8'h5A, 4'(8 + RD_LAT + 1)});
        at(12);
        cpu_rd = 1'b0;
        at(0);
        at(15);
        chk("cpu_dout_5a", 32'(cpu_dout), 32'h5A);
        chk("rd_cmdq", 32'(cmdq.size()), 32'd0);
        chk("rd_ackq", 32'(ackq.size()), 32'd0);
        // boot mode: boot write only, CPU dropped, no video
        boot_mode = 1'b1;
        at(2);
        boot_req = 1'b1; boot_addr = 23'h1ABCDE; boot_bank = 2'd1; boot_din = 8'h99;
        cpu_wr = 1'b1; cpu_addr = 23'h000007; cpu_din = 8'h55;
        cmdq.push_back(cmd_t'{1'b1, 23'h1ABCDE, 2'd1, 8'h99, 4'd8});
        ackq.push_back(ack_t'{3'b001, 8'h00, 4'd8});
        tick();
        boot_req = 1'b0;
        at(10);
        chk("boot_cmdq", 32'(cmdq.size()), 32'd0);
        chk("boot_ackq", 32'(ackq.size()), 32'd0);
        cpu_wr = 1'b0;
        // back-to-back boot strobes collapse into one command with the newest values
        at(3);
        boot_req = 1'b1; boot_addr = 23'h000010; boot_bank = 2'd0; boot_din = 8'hAA;
        tick();
        boot_addr = 23'h000020; boot_bank = 2'd3; boot_din = 8'hBB;
        cmdq.push_back(cmd_t'{1'b1, 23'h000020, 2'd3, 8'hBB, 4'd8});
        ackq.push_back(ack_t'{3'b001, 8'h00, 4'd8});
        tick();
        boot_req = 1'b0;
        at(10);
        chk("bootow_cmdq", 32'(cmdq.size()), 32'd0);
        chk("bootow_ackq", 32'(ackq.size()), 32'd0);
        at(15);
        boot_mode = 1'b0;
        exp_vid(16'h0F0F, 2'd1, 8'h3D);
        // reset while a CPU read is outstanding
        at(2);
        cpu_rd = 1'b1; cpu_addr = 23'h000100; cpu_bank = 2'd0; cpu_data = 8'hC3;
        cmdq.push_back(cmd_t'{1'b0, 23'h000100, 2'd0, 8'h0, 4'd8});
        at(10);
        cpu_rd = 1'b0;
        at(12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_rdv_seen", 32'(sd_rd_valid), 32'd1);
        chk("rstmid_tag", 32'(dut.tag), 32'(TAG_NONE));
        exp_vid(16'h5555, 2'd0, 8'h66);
        tick();
        chk("rstmid_cpu_dout", 32'(cpu_dout), 32'hFF);
        chk("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rstmid_vid_tag", 32'(dut.tag), 32'(TAG_VID));
        // clkref stops: phase saturates, no commands
        at(7);
        chk("vid_dout_66", 32'(vid_dout), 32'h66);
        clk_en = 1'b0;
        repeat (20) tick();
        chk("sat_phase", 32'(dut.phase), 32'd15);
        chk("sat_cmdq", 32'(cmdq.size()), 32'd0);
        // resume with a video read that never returns
        vid_addr = 16'h9999; vid_bank = 2'd2;
        cmdq.push_back(cmd_t'{1'b0, 23'h409999, 2'd2, 8'h0, 4'd0});
        core_mute = 1'b1;
        clk_en = 1'b1;
        at(0);
        at(7);
        chk("tmo_tag_held", 32'(dut.tag), 32'(TAG_VID));
        tick();
        chk("tmo_tag_clear", 32'(dut.tag), 32'(TAG_NONE));
        core_mute = 1'b0;
        at(12);
        exp_vid(16'hCAFE, 2'd3, 8'h81);
        at(3);
        cpu_wr = 1'b1; cpu_addr = 23'h3FFFFF; cpu_bank = 2'd1; cpu_din = 8'hE7;
        cmdq.push_back(cmd_t'{1'b1, 23'h3FFFFF, 2'd1, 8'hE7, 4'd8});
        ackq.push_back(ack_t'{3'b100, 8'hFF, 4'd8});
        at(10);
        cpu_wr = 1'b0;
        chk("end_cmdq", 32'(cmdq.size()), 32'd0);
        chk("end_ackq", 32'(ackq.size()), 32'd0);
        chk("vid_dout_81", 32'(vid_dout), 32'h81);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_slot_arbiter.md
Name: sdram_slot_arbiter

Overview:
- Time-slot arbiter in front of the single-port SDRAM core; shares it between the boot/ROM loader, the CPU memory bus and the CRTC video fetch.
- Each 16-cycle frame is aligned to the clkref pulse. Phase 0 is the video slot; phase 8 is the CPU/boot slot.
- It latches requests, issues one command per slot, steers read data back to its owner by tag, and pulses per-requester acks.

Parameters:
- ADDR_W, 23, SDRAM byte address width.
- RD_LAT, 5, cycles from sd_cmd_valid to sd_rd_valid. Legal range 1..7; elaboration error outside it.
- VID_HI, 7'b1000000, upper address bits prepended to vid_addr.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk_sys
- clkref  in  1  one-cycle pulse every 16 clk_sys; frame start
- boot_mode  in  1  high while ROM download is active; CPU and video slots suppressed
- boot_req  in  1  one-cycle write strobe from the loader
- boot_addr  in  ADDR_W  loader address
- boot_bank  in  2  loader bank
- boot_din  in  8  loader data
- boot_ack  out  1  pulse when the boot write is issued
- cpu_rd  in  1  level read request
- cpu_wr  in  1  level write request
- cpu_addr  in  ADDR_W  CPU address
- cpu_bank  in  2  CPU bank
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  last CPU read data
- cpu_ack  out  1  pulse when the write is issued, or when read data is valid
- vid_addr  in  16  video fetch address
- vid_bank  in  2  video bank
- vid_dout  out  8  last video byte
- vid_valid  out  1  pulse with new vid_dout
- sd_cmd_valid  out  1  one-cycle command strobe
- sd_cmd_we  out  1  1 = write
- sd_cmd_addr  out  ADDR_W  command address
- sd_cmd_bank  out  2  command bank
- sd_cmd_din  out  8  write data
- sd_rd_valid  in  1  read data strobe, RD_LAT after the read command
- sd_rd_data  in  8  read data

Behaviour:
- Reset:
  - phase=15 (idle), all pending flags and the tag cleared.
  - All strobes 0; cpu_dout=vid_dout=8'hFF; sd_cmd_* =0.
- Phase counter:
  - On clkref, phase<=0. Otherwise phase increments, saturating at 15.
  - Missing clkref: no new slots issued.
  - Early clkref: resync to 0. A read already outstanding still completes by its tag.
- Boot latch:
  - boot_req captures addr/bank/din and sets boot_pend.
  - boot_req while boot_pend: new values overwrite; a single command is issued.
- CPU latch:
  - A rising edge of (cpu_rd|cpu_wr) captures addr/bank/din and sets cpu_pend, with cpu_we=cpu_wr. If both are high, write wins.
  - Edges while cpu_pend are ignored.
  - Edges while boot_mode are dropped.
  - Falling edge before service does not cancel.
- Phase 0 (video slot):
  - Condition: boot_mode=0 and tag==NONE.
  - Issue read {VID_HI, vid_addr}, bank vid_bank; tag<=VID.
  - If the condition fails, the slot is idle.
- Phase 8 (CPU/boot slot), priority boot > CPU:
  - If boot_pend: issue write, boot_ack=1 in the same cycle, clear boot_pend.
  - Else if cpu_pend and not boot_mode:
    - Write: issue write, cpu_ack=1 in the same cycle, clear cpu_pend.
    - Read: issue read, tag<=CPU, clear cpu_pend.
- Read return:
  - On sd_rd_valid, route sd_rd_data by tag:
    - VID: vid_dout, vid_valid pulse.
    - CPU: cpu_dout, cpu_ack pulse.
  - Then tag<=NONE.
  - sd_rd_valid with tag NONE is discarded.
- A read-data timeout of RD_LAT+2 cycles without sd_rd_valid forces tag<=NONE, no ack. This guards against CPU stall on a glitching core.
- Latency:
  - Write ack arrives 1..16 cycles after the request edge.
  - CPU read ack = slot wait + RD_LAT + 1 (registered output).
- sd_cmd_valid is never high in two consecutive cycles; at most 2 commands per frame.
- A reset in mid-operation abandons the outstanding read; no ack is produced.

Decomposition:
- Package amstrad_mem_pkg:
  - typedef enum logic[1:0] {TAG_NONE, TAG_VID, TAG_CPU} mem_tag_e.
  - Constants PH_VID=4'd0, PH_CPU=4'd8, FRAME_LEN=16.
- Sub-module mem_req_latch (edge detect plus capture plus pending flag), instantiated once for the CPU port. The boot port uses the strobe-capture mode of the same sub-module via a parameter.

Test Plan:
- clkref every 16; vid_addr=16'h1234; sd_rd_data=8'hA5 at RD_LAT → cmd at phase 0 addr 23'h401234 we=0; vid_valid one cycle, vid_dout=A5.
- cpu_wr rise at phase 3, addr 23'h00C000 din 8'h3C → command at phase 8 we=1 din=3C; cpu_ack in the same cycle; holding cpu_wr high produces no second command.
- cpu_rd rise at phase 9 (slot missed), read returns 8'h5A → command at the next frame's phase 8; cpu_ack with cpu_dout=5A at phase 8+RD_LAT+1.
- boot_mode=1; boot_req and cpu_wr at phase 2 → only the boot write issued at phase 8, boot_ack pulses; no video command; the CPU request is dropped.
- Read issued, reset asserted at RD_LAT-1, then sd_rd_valid arrives → no cpu_ack; cpu_dout=FF; tag NONE.
- clkref stops after phase 0 → phase saturates at 15, no sd_cmd_valid. Read issued, sd_rd_valid never arrives → tag clears after RD_LAT+2 cycles; the next clkref resumes normal slots.
